lcd_timing_gen: RTL and testbench

- Generates the raster for the 800x480 panel and drives the `x`/`y` scan coordinates into GPU_core.
- Takes back the GPU's `R`/`G`/`B` pixel, together with its `res_x`/`res_y` and flip controls.
- Re-times hsync/vsync/data-enable so they line up with the GPU's fixed read latency, and presents registered panel signals.
- Sits between GPU_core's monitor interface and the LCD pins.

---
 rtl/lcd_timing_gen_if.sv | 25 ++
 rtl/lcd_timing_gen.sv | 208 ++++++++++++++++++++
 tb/tb_lcd_timing_gen.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_timing_gen_if.sv
// GPU monitor-side bundle for lcd_timing_gen.
//   master (timing generator): drives x/y scan coordinates, receives R/G/B pixel,
//                              resolution and flip controls.
//   slave  (GPU side)        : receives x/y, drives pixel, resolution and flips.
interface lcd_timing_gen_if;
    logic [9:0] res_x;        // last active column index
    logic [8:0] res_y;        // last active line index
    logic       flipHenable;  // mirror x
    logic       flipVenable;  // mirror y
    logic       R;            // pixel from GPU, PIPE_LAT clocks after x/y
    logic       G;
    logic       B;
    logic [9:0] x;            // column coordinate to GPU
    logic [8:0] y;            // line coordinate to GPU

    modport master (
        input  res_x, res_y, flipHenable, flipVenable, R, G, B,
        output x, y
    );

    modport slave (
        output res_x, res_y, flipHenable, flipVenable, R, G, B,
        input  x, y
    );
endinterface

// File: rtl/lcd_timing_gen.sv
// Raster timing generator for an RGB LCD panel fed by a fixed-latency GPU.
// Ports:
//   clk, rst       pixel clock, synchronous active-high reset
//   gpu (master)   x/y out, R/G/B in, res_x/res_y/flip controls in
//   lcd_r/g/b      registered panel pixel data
//   lcd_de         registered data enable
//   lcd_hs/lcd_vs  registered syncs, active low
//   frame_start    one-clock pulse aligned with x/y of the first frame clock
module lcd_timing_gen #(
    parameter int unsigned H_FP     = 40,
    parameter int unsigned H_SYNC   = 48,
    parameter int unsigned H_BP     = 40,
    parameter int unsigned V_FP     = 13,
    parameter int unsigned V_SYNC   = 3,
    parameter int unsigned V_BP     = 29,
    parameter int unsigned PIPE_LAT = 3
) (
    input  logic                clk,
    input  logic                rst,
    lcd_timing_gen_if.master    gpu,
    output logic                lcd_r,
    output logic                lcd_g,
    output logic                lcd_b,
    output logic                lcd_de,
    output logic                lcd_hs,
    output logic                lcd_vs,
    output logic                frame_start
);

    localparam int unsigned HCW     = 11;
    localparam int unsigned VCW     = 10;
    localparam int unsigned XW      = 10;
    localparam int unsigned YW      = 9;
    localparam int unsigned H_BLANK = H_FP + H_SYNC + H_BP;
    localparam int unsigned V_BLANK = V_FP + V_SYNC + V_BP;

    // Frame configuration, held constant for a whole frame
    logic [XW-1:0]  res_x_l_q, res_x_l_d;
    logic [YW-1:0]  res_y_l_q, res_y_l_d;
    logic           flip_h_l_q, flip_h_l_d;
    logic           flip_v_l_q, flip_v_l_d;

    // Raster counters
    logic [HCW-1:0] hcnt_q, hcnt_d;
    logic [VCW-1:0] vcnt_q, vcnt_d;

    // Coordinate stage
    logic [XW-1:0]  x_q, x_d;
    logic [YW-1:0]  y_q, y_d;
    logic           act_q, act_d;
    logic           hs_q, hs_d;
    logic           vs_q, vs_d;
    logic           fs_q, fs_d;

    // Delay line matching the GPU read latency
    logic [PIPE_LAT-1:0] act_dly_q, act_dly_d;
    logic [PIPE_LAT-1:0] hs_dly_q, hs_dly_d;
    logic [PIPE_LAT-1:0] vs_dly_q, vs_dly_d;
    logic [PIPE_LAT:0]   act_sh_c, hs_sh_c, vs_sh_c;

    // Panel output stage
    logic           lcd_r_q, lcd_r_d;
    logic           lcd_g_q, lcd_g_d;
    logic           lcd_b_q, lcd_b_d;
    logic           lcd_de_q, lcd_de_d;
    logic           lcd_hs_q, lcd_hs_d;
    logic           lcd_vs_q, lcd_vs_d;

    // Raster decode
    logic           h_last_c, v_last_c, frame_wrap_c;
    logic           h_act_c, v_act_c, act_c;
    logic [HCW-1:0] hs_lo_c, hs_hi_c;
    logic [VCW-1:0] vs_lo_c, vs_hi_c;

    // Counter wrap points and sync windows derived from the latched resolution
    always_comb begin
        h_last_c     = (hcnt_q == (HCW'(res_x_l_q) + HCW'(H_BLANK)));
        v_last_c     = (vcnt_q == (VCW'(res_y_l_q) + VCW'(V_BLANK)));
        frame_wrap_c = h_last_c & v_last_c;

        h_act_c = (hcnt_q <= HCW'(res_x_l_q));
        v_act_c = (vcnt_q <= VCW'(res_y_l_q));
        act_c   = h_act_c & v_act_c;

        hs_lo_c = HCW'(res_x_l_q) + HCW'(H_FP + 1);
        hs_hi_c = HCW'(res_x_l_q) + HCW'(H_FP + H_SYNC);
        vs_lo_c = VCW'(res_y_l_q) + VCW'(V_FP + 1);
        vs_hi_c = VCW'(res_y_l_q) + VCW'(V_FP + V_SYNC);
    end

    // Configuration reload happens only at the frame wrap
    always_comb begin
        res_x_l_d  = res_x_l_q;
        res_y_l_d  = res_y_l_q;
        flip_h_l_d = flip_h_l_q;
        flip_v_l_d = flip_v_l_q;
        if (frame_wrap_c) begin
            res_x_l_d  = gpu.res_x;
            res_y_l_d  = gpu.res_y;
            flip_h_l_d = gpu.flipHenable;
            flip_v_l_d = gpu.flipVenable;
        end
    end

    // Horizontal / vertical counters
    always_comb begin
        hcnt_d = hcnt_q + HCW'(1);
        vcnt_d = vcnt_q;
        if (h_last_c) begin
            hcnt_d = '0;
            vcnt_d = v_last_c ? '0 : (vcnt_q + VCW'(1));
        end
    end

    // Coordinate stage; subtraction only in the active region so it never underflows
    always_comb begin
        x_d  = '0;
        y_d  = '0;
        if (act_c) begin
            x_d = flip_h_l_q ? (res_x_l_q - XW'(hcnt_q)) : XW'(hcnt_q);
            y_d = flip_v_l_q ? (res_y_l_q - YW'(vcnt_q)) : YW'(vcnt_q);
        end
        act_d = act_c;
        hs_d  = (hcnt_q >= hs_lo_c) && (hcnt_q <= hs_hi_c);
        vs_d  = (vcnt_q >= vs_lo_c) && (vcnt_q <= vs_hi_c);
        fs_d  = (hcnt_q == '0) && (vcnt_q == '0);
    end

    // Shift registers: bit 0 takes the coordinate stage, top bit feeds the pins
    always_comb begin
        act_sh_c  = {act_dly_q, act_q};
        hs_sh_c   = {hs_dly_q, hs_q};
        vs_sh_c   = {vs_dly_q, vs_q};
        act_dly_d = act_sh_c[PIPE_LAT-1:0];
        hs_dly_d  = hs_sh_c[PIPE_LAT-1:0];
        vs_dly_d  = vs_sh_c[PIPE_LAT-1:0];
    end

    // Panel stage: pixel gated by the delayed data enable
    always_comb begin
        lcd_de_d = act_dly_q[PIPE_LAT-1];
        lcd_hs_d = ~hs_dly_q[PIPE_LAT-1];
        lcd_vs_d = ~vs_dly_q[PIPE_LAT-1];
        lcd_r_d  = act_dly_q[PIPE_LAT-1] & gpu.R;
        lcd_g_d  = act_dly_q[PIPE_LAT-1] & gpu.G;
        lcd_b_d  = act_dly_q[PIPE_LAT-1] & gpu.B;
    end

    // All state; configuration tracks the inputs while in reset
    always_ff @(posedge clk) begin
        if (rst) begin
            res_x_l_q  <= gpu.res_x;
            res_y_l_q  <= gpu.res_y;
            flip_h_l_q <= gpu.flipHenable;
            flip_v_l_q <= gpu.flipVenable;
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            x_q        <= '0;
            y_q        <= '0;
            act_q      <= 1'b0;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            fs_q       <= 1'b0;
            act_dly_q  <= '0;
            hs_dly_q   <= '0;
            vs_dly_q   <= '0;
            lcd_r_q    <= 1'b0;
            lcd_g_q    <= 1'b0;
            lcd_b_q    <= 1'b0;
            lcd_de_q   <= 1'b0;
            lcd_hs_q   <= 1'b1;
            lcd_vs_q   <= 1'b1;
        end else begin
            res_x_l_q  <= res_x_l_d;
            res_y_l_q  <= res_y_l_d;
            flip_h_l_q <= flip_h_l_d;
            flip_v_l_q <= flip_v_l_d;
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            act_q      <= act_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            fs_q       <= fs_d;
            act_dly_q  <= act_dly_d;
            hs_dly_q   <= hs_dly_d;
            vs_dly_q   <= vs_dly_d;
            lcd_r_q    <= lcd_r_d;
            lcd_g_q    <= lcd_g_d;
            lcd_b_q    <= lcd_b_d;
            lcd_de_q   <= lcd_de_d;
            lcd_hs_q   <= lcd_hs_d;
            lcd_vs_q   <= lcd_vs_d;
        end
    end

    assign gpu.x       = x_q;
    assign gpu.y       = y_q;
    assign frame_start = fs_q;
    assign lcd_r       = lcd_r_q;
    assign lcd_g       = lcd_g_q;
    assign lcd_b       = lcd_b_q;
    assign lcd_de      = lcd_de_q;
    assign lcd_hs      = lcd_hs_q;
    assign lcd_vs      = lcd_vs_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: small-raster instance checked every cycle against a
// position-based raster model, plus a default 800x480 instance for line timing.
module tb_lcd_timing_gen;

    localparam int P   = 3;
    localparam int HFP = 2;
    localparam int HS  = 2;
    localparam int HBP = 2;
    localparam int VFP = 1;
    localparam int VS  = 1;
    localparam int VBP = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst   = 1'b1;
    logic       rst2  = 1'b1;
    logic [9:0] in_rx = 10'd9;
    logic [8:0] in_ry = 9'd4;
    logic       in_fh = 1'b0;
    logic       in_fv = 1'b0;
    logic       gpu_r = 1'b0;
    logic       gpu_g = 1'b0;
    logic       gpu_b = 1'b0;

    lcd_timing_gen_if gif ();
    assign gif.res_x       = in_rx;
    assign gif.res_y       = in_ry;
    assign gif.flipHenable = in_fh;
    assign gif.flipVenable = in_fv;
    assign gif.R           = gpu_r;
    assign gif.G           = gpu_g;
    assign gif.B           = gpu_b;

    logic lcd_r, lcd_g, lcd_b, lcd_de, lcd_hs, lcd_vs, frame_start;

    lcd_timing_gen #(
        .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .PIPE_LAT(P)
    ) dut (
        .clk(clk), .rst(rst), .gpu(gif),
        .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b),
        .lcd_de(lcd_de), .lcd_hs(lcd_hs), .lcd_vs(lcd_vs),
        .frame_start(frame_start)
    );

    lcd_timing_gen_if gif2 ();
    assign gif2.res_x       = 10'd799;
    assign gif2.res_y       = 9'd479;
    assign gif2.flipHenable = 1'b0;
    assign gif2.flipVenable = 1'b0;
    assign gif2.R           = 1'b0;
    assign gif2.G           = 1'b0;
    assign gif2.B           = 1'b0;

    logic d2_r, d2_g, d2_b, d2_de, d2_hs, d2_vs, d2_fs;

    lcd_timing_gen dut2 (
        .clk(clk), .rst(rst2), .gpu(gif2),
        .lcd_r(d2_r), .lcd_g(d2_g), .lcd_b(d2_b),
        .lcd_de(d2_de), .lcd_hs(d2_hs), .lcd_vs(d2_vs),
        .frame_start(d2_fs)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
    endtask

    // ---------------- raster model ----------------
    typedef struct {
        bit act;
        bit hs;
        bit vs;
        bit fs;
        int x;
        int y;
    } stage_t;

    function automatic int frame_len(input int rx, input int ry);
        return (rx + 1 + HFP + HS + HBP) * (ry + 1 + VFP + VS + VBP);
    endfunction

    // What the coordinate stage must show for frame position pos
    function automatic stage_t stage_of(input int pos, input int rx, input int ry,
                                        input bit fh, input bit fv);
        stage_t s;
        int htot, hc, vc;
        htot  = rx + 1 + HFP + HS + HBP;
        hc    = pos % htot;
        vc    = pos / htot;
        s.act = (hc <= rx) && (vc <= ry);
        s.hs  = (hc > rx + HFP) && (hc <= rx + HFP + HS);
        s.vs  = (vc > ry + VFP) && (vc <= ry + VFP + VS);
        s.fs  = (pos == 0);
        s.x   = s.act ? (fh ? rx - hc : hc) : 0;
        s.y   = s.act ? (fv ? ry - vc : vc) : 0;
        return s;
    endfunction

    stage_t hist [16];
    stage_t e_st;
    int  m_pos = 0, m_rx = 9, m_ry = 4;
    bit  m_fh = 0, m_fv = 0;
    int  cyc = 0;
    int  last_rst = 0;
    bit  exp_valid = 0;
    bit  e_de, e_hs, e_vs, e_r, e_g, e_b;
    logic [9:0] gx [8];
    logic [8:0] gy [8];

    // measurement state
    int  last_fs = -1, fs_int = 0;
    bit  prev_de = 0, prev_hs = 1;
    int  run_len = 0, last_de_fall = -100000;
    int  c_runs = 0, c_rmin = 1000000, c_rmax = 0, c_vs = 0, c_hs = 0, c_gap = 1000000;
    int  w_runs = 0, w_rmin = 0, w_rmax = 0, w_vs = 0, w_hs = 0, w_gap = 0;
    bit  p2_hs = 1, p2_de = 0;
    int  d2_last_fall = -1, d2_hs_int = 0, d2_len = 0, d2_run = 0, d2_fs_cnt = 0;

    initial begin
        for (int i = 0; i < 8; i++) begin
            gx[i] = '0;
            gy[i] = '0;
        end
    end

    // Compare, GPU model, raster model and measurement, once per cycle
    always @(negedge clk) begin
        stage_t s;
        stage_t o;
        if (exp_valid) begin
            chk("x", 32'(gif.x), e_st.x);
            chk("y", 32'(gif.y), e_st.y);
            chk("frame_start", 32'(frame_start), 32'(e_st.fs));
            chk("lcd_de", 32'(lcd_de), 32'(e_de));
            chk("lcd_hs", 32'(lcd_hs), 32'(e_hs));
            chk("lcd_vs", 32'(lcd_vs), 32'(e_vs));
            chk("lcd_r", 32'(lcd_r), 32'(e_r));
            chk("lcd_g", 32'(lcd_g), 32'(e_g));
            chk("lcd_b", 32'(lcd_b), 32'(e_b));
        end

        // GPU: pixel for coordinate C appears P clocks after C
        for (int i = 7; i > 0; i--) begin
            gx[i] = gx[i-1];
            gy[i] = gy[i-1];
        end
        gx[0] = gif.x;
        gy[0] = gif.y;
        gpu_r = gx[P][0];
        gpu_g = gy[P][0];
        gpu_b = gx[P][1];

        // Stage contents visible next cycle
        if (rst) begin
            last_rst = cyc;
            s = '{default: 0};
            m_pos = 0;
            m_rx = int'(in_rx); m_ry = int'(in_ry); m_fh = in_fh; m_fv = in_fv;
        end else begin
            s = stage_of(m_pos, m_rx, m_ry, m_fh, m_fv);
            if (m_pos == frame_len(m_rx, m_ry) - 1) begin
                m_pos = 0;
                m_rx = int'(in_rx); m_ry = int'(in_ry); m_fh = in_fh; m_fv = in_fv;
            end else begin
                m_pos++;
            end
        end
        hist[(cyc + 1) % 16] = s;
        e_st = s;

        // Pins next cycle show the stage from P cycles back unless a reset intervened
        if (cyc - last_rst <= P) begin
            e_de = 0; e_hs = 1; e_vs = 1; e_r = 0; e_g = 0; e_b = 0;
        end else begin
            o    = hist[(cyc - P) % 16];
            e_de = o.act;
            e_hs = !o.hs;
            e_vs = !o.vs;
            e_r  = o.act && o.x[0];
            e_g  = o.act && o.y[0];
            e_b  = o.act && o.x[1];
        end
        exp_valid = 1;

        // Per-frame window measurements on the small instance
        if (frame_start === 1'b1) begin
            if (last_fs >= 0) fs_int = cyc - last_fs;
            last_fs = cyc;
            w_runs = c_runs; w_rmin = c_rmin; w_rmax = c_rmax;
            w_vs = c_vs; w_hs = c_hs; w_gap = c_gap;
            c_runs = 0; c_rmin = 1000000; c_rmax = 0; c_vs = 0; c_hs = 0; c_gap = 1000000;
        end
        if (lcd_de && !prev_de) begin
            c_runs++;
            run_len = 0;
        end
        if (lcd_de) run_len++;
        if (!lcd_de && prev_de) begin
            if (run_len < c_rmin) c_rmin = run_len;
            if (run_len > c_rmax) c_rmax = run_len;
            last_de_fall = cyc;
        end
        if (!lcd_hs && prev_hs && (cyc - last_de_fall < c_gap)) c_gap = cyc - last_de_fall;
        if (!lcd_hs) c_hs++;
        if (!lcd_vs) c_vs++;
        prev_de = lcd_de;
        prev_hs = lcd_hs;

        // Default-size instance: line period and active run length
        if (d2_fs === 1'b1) d2_fs_cnt++;
        if (!d2_hs && p2_hs) begin
            if (d2_last_fall >= 0) d2_hs_int = cyc - d2_last_fall;
            d2_last_fall = cyc;
        end
        if (d2_de) d2_len++;
        if (!d2_de && p2_de) begin
            d2_run = d2_len;
            d2_len = 0;
        end
        p2_hs = d2_hs;
        p2_de = d2_de;

        cyc++;
    end

    task automatic wait_fs();
        bit seen;
        seen = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk("wait_fs_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        // Reset and release
        repeat (3) @(posedge clk);
        #2;
        rst  = 1'b0;
        rst2 = 1'b0;
        @(negedge clk);
        chk("rel_fs_low", 32'(frame_start), 32'd0);
        chk("rel_hs_idle", 32'(lcd_hs), 32'd1);
        chk("rel_vs_idle", 32'(lcd_vs), 32'd1);
        chk("rel_de_low", 32'(lcd_de), 32'd0);
        @(negedge clk);
        chk("rel_fs_pulse", 32'(frame_start), 32'd1);
        chk("rel_x0", 32'(gif.x), 32'd0);
        repeat (3) @(negedge clk);
        chk("de_before_rise", 32'(lcd_de), 32'd0);
        @(negedge clk);
        chk("de_first_rise", 32'(lcd_de), 32'd1);
        chk("r_first_px", 32'(lcd_r), 32'd0);
        @(negedge clk);
        chk("r_second_px", 32'(lcd_r), 32'd1);

        // Full-frame timing on a 10x5 raster
        wait_fs();
        wait_fs();
        @(posedge clk);
        #2;
        chk("frame_period", 32'(fs_int), 32'd128);
        chk("de_runs", 32'(w_runs), 32'd5);
        chk("de_run_min", 32'(w_rmin), 32'd10);
        chk("de_run_max", 32'(w_rmax), 32'd10);
        chk("vs_low_clks", 32'(w_vs), 32'd16);
        chk("hs_low_clks", 32'(w_hs), 32'd16);
        chk("hs_after_de", 32'(w_gap), 32'd2);

        // Flips requested mid-frame apply from the next frame
        in_fh = 1'b1;
        in_fv = 1'b1;
        wait_fs();
        chk("flip_x_first", 32'(gif.x), 32'd9);
        chk("flip_y_first", 32'(gif.y), 32'd4);
        @(posedge clk);
        #2;
        in_fh = 1'b0;
        in_fv = 1'b0;

        // Width change at line 2 takes effect one frame later
        wait_fs();
        repeat (32) @(posedge clk);
        #2;
        in_rx = 10'd7;
        wait_fs();
        @(posedge clk);
        #2;
        chk("old_width_min", 32'(w_rmin), 32'd10);
        chk("old_width_max", 32'(w_rmax), 32'd10);
        wait_fs();
        @(posedge clk);
        #2;
        chk("new_width_min", 32'(w_rmin), 32'd8);
        chk("new_width_max", 32'(w_rmax), 32'd8);
        chk("new_width_runs", 32'(w_runs), 32'd5);
        chk("new_frame_period", 32'(fs_int), 32'd112);
        in_rx = 10'd9;

        // One-clock reset at hcnt=5, vcnt=3
        wait_fs();
        repeat (52) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_de", 32'(lcd_de), 32'd0);
        chk("rst_hs", 32'(lcd_hs), 32'd1);
        chk("rst_vs", 32'(lcd_vs), 32'd1);
        chk("rst_rgb", 32'({lcd_r, lcd_g, lcd_b}), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);
        @(negedge clk);
        chk("rst_fs_pulse", 32'(frame_start), 32'd1);
        wait_fs();
        @(posedge clk);
        #2;
        chk("rst_frame_period", 32'(fs_int), 32'd128);

        // Default 800x480 instance line timing
        while (cyc < 3200) @(posedge clk);
        chk("dflt_line_period", 32'(d2_hs_int), 32'd928);
        chk("dflt_de_run", 32'(d2_run), 32'd800);
        chk("dflt_one_frame_start", 32'(d2_fs_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
